id_ex_hazard_stage: RTL

- ID/EX pipeline register combined with load-use hazard detection for the 5-stage RISC-V pipeline.
- Latches decoded ID-stage operands and control signals into the EX stage.
- Drives the source/destination indices and regwrite flag that the forwarding logic consumes.
- Generates the IF/ID stall, inserts bubbles on load-use hazards and branch flushes, and counts stall cycles.

---
 rtl/riscv_pkg.sv | 32 +++
 rtl/hazard_detect.sv | 28 ++
 rtl/id_ex_hazard_stage.sv | 119 +++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the 5-stage RISC-V pipeline: datapath width,
// ALU op encodings, register-zero index and the EX-stage bubble control word.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLL    = 4'd2,
        ALU_SLT    = 4'd3,
        ALU_SLTU   = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_OR     = 4'd8,
        ALU_AND    = 4'd9,
        ALU_PASS_B = 4'd10
    } alu_op_e;

    typedef struct packed {
        logic valid;
        logic regwrite;
        logic memread;
        logic memwrite;
    } ex_ctrl_t;

    localparam ex_ctrl_t BUBBLE_CTRL = '{valid: 1'b0, regwrite: 1'b0, memread: 1'b0, memwrite: 1'b0};

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use compare: the ID instruction reads a register that
// the load currently in EX has not produced yet.
module hazard_detect
    import riscv_pkg::*;
(
    input  logic       id_valid,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    input  logic       ex_valid,
    input  logic       ex_memread,
    input  logic [4:0] ex_rd,
    output logic       hazard
);

    logic load_in_ex;
    logic rs1_match;
    logic rs2_match;

    always_comb begin
        load_in_ex = id_valid && ex_valid && ex_memread && (ex_rd != REG_ZERO);
        rs1_match  = id_uses_rs1 && (id_rs1 == ex_rd);
        rs2_match  = id_uses_rs2 && (id_rs2 == ex_rd);
        hazard     = load_in_ex && (rs1_match || rs2_match);
    end

endmodule

// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with load-use stall generation, bubble insertion
// on hazards and branch flushes, and a saturating stall-cycle counter.
module id_ex_hazard_stage #(
    parameter int XLEN  = riscv_pkg::XLEN,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ID_valid,
    input  logic [4:0]       ID_rs1,
    input  logic [4:0]       ID_rs2,
    input  logic [4:0]       ID_rd,
    input  logic             ID_uses_rs1,
    input  logic             ID_uses_rs2,
    input  logic             ID_regwrite,
    input  logic             ID_memread,
    input  logic             ID_memwrite,
    input  logic [3:0]       ID_aluop,
    input  logic [XLEN-1:0]  ID_rdata1,
    input  logic [XLEN-1:0]  ID_rdata2,
    input  logic [XLEN-1:0]  ID_imm,
    input  logic [XLEN-1:0]  ID_pc,
    input  logic             EX_flush,
    input  logic             MEM_hold,
    output logic             EX_valid,
    output logic             EX_regwrite,
    output logic             EX_memread,
    output logic             EX_memwrite,
    output logic [4:0]       Indice_rs1,
    output logic [4:0]       Indice_rs2,
    output logic [4:0]       EX_rd,
    output logic [3:0]       EX_aluop,
    output logic [XLEN-1:0]  EX_rdata1,
    output logic [XLEN-1:0]  EX_rdata2,
    output logic [XLEN-1:0]  EX_imm,
    output logic [XLEN-1:0]  EX_pc,
    output logic             stall_IF,
    output logic [CNT_W-1:0] stall_count
);

    import riscv_pkg::*;

    ex_ctrl_t ctrl_q;
    ex_ctrl_t id_ctrl;
    logic     hazard;

    hazard_detect u_hazard_detect (
        .id_valid    (ID_valid),
        .id_rs1      (ID_rs1),
        .id_rs2      (ID_rs2),
        .id_uses_rs1 (ID_uses_rs1),
        .id_uses_rs2 (ID_uses_rs2),
        .ex_valid    (ctrl_q.valid),
        .ex_memread  (ctrl_q.memread),
        .ex_rd       (EX_rd),
        .hazard      (hazard)
    );

    // A flush overrides the stall: the dependent instruction is being squashed anyway.
    always_comb begin
        stall_IF = MEM_hold || (hazard && !EX_flush);
    end

    always_comb begin
        id_ctrl.valid    = ID_valid;
        id_ctrl.regwrite = ID_regwrite && ID_valid;
        id_ctrl.memread  = ID_memread  && ID_valid;
        id_ctrl.memwrite = ID_memwrite && ID_valid;
    end

    assign EX_valid    = ctrl_q.valid;
    assign EX_regwrite = ctrl_q.regwrite;
    assign EX_memread  = ctrl_q.memread;
    assign EX_memwrite = ctrl_q.memwrite;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q      <= BUBBLE_CTRL;
            Indice_rs1  <= '0;
            Indice_rs2  <= '0;
            EX_rd       <= '0;
            EX_aluop    <= '0;
            EX_rdata1   <= '0;
            EX_rdata2   <= '0;
            EX_imm      <= '0;
            EX_pc       <= '0;
            stall_count <= '0;
        end else begin
            if (stall_IF && (stall_count != '1)) begin
                stall_count <= stall_count + CNT_W'(1);
            end
            // MEM_hold freezes EX entirely, leaving any pending flush unconsumed.
            if (!MEM_hold) begin
                if (EX_flush || hazard) begin
                    ctrl_q     <= BUBBLE_CTRL;
                    Indice_rs1 <= '0;
                    Indice_rs2 <= '0;
                    EX_rd      <= '0;
                    EX_aluop   <= '0;
                    EX_rdata1  <= '0;
                    EX_rdata2  <= '0;
                    EX_imm     <= '0;
                    EX_pc      <= '0;
                end else begin
                    ctrl_q     <= id_ctrl;
                    Indice_rs1 <= ID_rs1;
                    Indice_rs2 <= ID_rs2;
                    EX_rd      <= ID_rd;
                    EX_aluop   <= ID_aluop;
                    EX_rdata1  <= ID_rdata1;
                    EX_rdata2  <= ID_rdata2;
                    EX_imm     <= ID_imm;
                    EX_pc      <= ID_pc;
                end
            end
        end
    end

endmodule
